// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Performs the host request-to-send sequence (clock inhibit, start bit,
// 8 data bits LSB first, odd parity, stop, device ACK) on the shared
// open-collector ps2 clock/data pins via output enables.
// Optional feature: define PS2_TX_WATCHDOG_EN to abort a transfer when the
// device stops clocking for TIMEOUT_MS.
module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 48000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_CYC  = (CLK_HZ / 1000000) * INHIBIT_US;
  localparam int unsigned INH_W    = (INH_CYC > 2) ? $clog2(INH_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
  localparam int unsigned WD_CYC   = (CLK_HZ / 1000) * TIMEOUT_MS;

  // Reject parameter sets whose inhibit or watchdog count cannot be represented.
  if (INH_CYC == 0 || WD_CYC > 32'h000F_FFFF) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_US/TIMEOUT_MS out of range for CLK_HZ");
  end

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE,
    FINISH      // one-cycle slot carrying the done/error pulse before IDLE
  } state_t;

  state_t           state, state_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [3:0]       idx, idx_n;
  logic             parity, parity_n;
  logic             data_oe_n, done_n, error_n;

  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;
  logic fall;

`ifdef PS2_TX_WATCHDOG_EN
  localparam logic [19:0] WD_LOAD = 20'(WD_CYC);
  logic [19:0] wd_cnt, wd_cnt_n;
`endif

  // Two-stage synchronizers for the pins plus one extra clock stage for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      shift       <= '0;
      idx         <= '0;
      parity      <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      shift       <= shift_n;
      idx         <= idx_n;
      parity      <= parity_n;
      tx_ready    <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
      done        <= done_n;
      error       <= error_n;
      ps2_clk_oe  <= (state_n == INHIBIT);
      ps2_data_oe <= data_oe_n;
`ifdef PS2_TX_WATCHDOG_EN
      wd_cnt      <= wd_cnt_n;
`endif
    end
  end

  // Next-state logic; the data line only moves on a detected clock fall.
  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    shift_n   = shift;
    idx_n     = idx;
    parity_n  = parity;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;
`ifdef PS2_TX_WATCHDOG_EN
    wd_cnt_n  = wd_cnt;
`endif

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n   = INHIBIT;
          shift_n   = tx_data;
          parity_n  = ~^tx_data;
          inh_cnt_n = INH_LOAD;
          idx_n     = '0;
        end
      end
      INHIBIT: begin
        if (inh_cnt == '0) begin
          state_n   = REQ;
          data_oe_n = 1'b1;
          idx_n     = '0;
        end else begin
          inh_cnt_n = inh_cnt - 1'b1;
        end
      end
      REQ: begin
        if (fall) begin
          state_n   = DATA;
          data_oe_n = ~shift[0];
          idx_n     = 4'd1;
        end
      end
      DATA: begin
        if (fall) begin
          if (idx == 4'd8) begin
            state_n   = PARITY;
            data_oe_n = ~parity;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            data_oe_n = ~shift[1];
            idx_n     = idx + 4'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          state_n   = STOP;
          data_oe_n = 1'b0;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = ACK;
        end
      end
      ACK: begin
        if (data_s2) begin
          state_n = FINISH;
          error_n = 1'b1;
        end else begin
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          state_n = FINISH;
          done_n  = 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef PS2_TX_WATCHDOG_EN
    if (state == INHIBIT && state_n == REQ) begin
      wd_cnt_n = WD_LOAD;
    end else if (state inside {REQ, DATA, PARITY, STOP, ACK}) begin
      if (fall) begin
        wd_cnt_n = WD_LOAD;
      end else if (wd_cnt == '0) begin
        state_n = FINISH;
        error_n = 1'b1;
        done_n  = 1'b0;
      end else begin
        wd_cnt_n = wd_cnt - 20'd1;
      end
    end
`endif

    if (state_n == IDLE || state_n == FINISH) begin
      data_oe_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Open-collector bus: a line is low if either side pulls it.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ(48000000),
    .INHIBIT_US(100),
    .TIMEOUT_MS(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

  // Request one byte and play the device side: 11 clock pulses, optional ACK.
  // frame[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop as seen on the pin.
  task automatic xfer(input logic [7:0] b, input bit ack, input bit spam,
                      output logic [10:0] frame, output int inh_len,
                      output logic oe_pre, output logic oe_post);
    int n;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk); #1;
    tx_valid = spam;
    tx_data  = spam ? 8'h00 : b;
    inh_len = 0;
    while (ps2_clk_oe && inh_len < 10000) begin
      inh_len++;
      @(posedge clk); #1;
    end
    repeat (20) @(posedge clk);
    #1;
    frame = '0;
    frame[0] = ps2_data_in;
    oe_pre = 1'b0;
    oe_post = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      if (k == 10) tx_valid = 1'b0;
      dev_clk_low = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (k == 1) oe_pre = ps2_data_oe;
      @(posedge clk); #1;
      if (k == 1) oe_post = ps2_data_oe;
      repeat (HALF - 3) @(posedge clk);
      #1;
      dev_clk_low = 1'b0;
      if (k <= 10) frame[k] = ps2_data_in;
      if (k == 11) dev_data_low = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
    end
    n = 0;
    while (!tx_ready && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [10:0] frame;
    int          inh_len;
    logic        oe_pre, oe_post;
    int          d0, e0, n;

    // Reset values
    #23;
    `CHK("rst_tx_ready", tx_ready, 1'b1)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done_error", {done, error}, 2'b00)
    `CHK("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00)
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Acceptance timing: one cycle after the accepting edge
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    `CHK("pre_accept_ready", tx_ready, 1'b1)
    @(posedge clk); #1;
    tx_valid = 1'b0;
    `CHK("accept_ready_low", tx_ready, 1'b0)
    `CHK("accept_busy_high", busy, 1'b1)
    `CHK("accept_clk_oe_high", ps2_clk_oe, 1'b1)
    reset_n = 1'b0;
    #1;
    `CHK("abort_inhibit_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00)
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 0xED with a busy-time request for 0x00 that must be ignored.
    // Frame: stop=1 parity=1 data=ED start=0 -> 111_1101_1010
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hED, 1'b1, 1'b1, frame, inh_len, oe_pre, oe_post);
    `CHK("ed_frame", frame, 11'h7DA)
    `CHK("ed_inhibit_len", inh_len, 4800)
    `CHK("ed_start_held_2cyc", oe_pre, 1'b1)
    `CHK("ed_bit0_at_3cyc", oe_post, 1'b0)
    `CHK("ed_done_once", done_cnt - d0, 1)
    `CHK("ed_no_error", err_cnt - e0, 0)
    `CHK("ed_ready_after", tx_ready, 1'b1)
    repeat (5) @(posedge clk);
    #1;
    `CHK("ed_no_second_accept", busy, 1'b0)

    // 0xF4: parity 0. Frame: stop=1 parity=0 data=F4 start=0 -> 101_1110_1000
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hF4, 1'b1, 1'b0, frame, inh_len, oe_pre, oe_post);
    `CHK("f4_frame", frame, 11'h5E8)
    `CHK("f4_inhibit_len", inh_len, 4800)
    `CHK("f4_bit0_at_3cyc", oe_post, 1'b1)
    `CHK("f4_done_once", done_cnt - d0, 1)
    `CHK("f4_no_error", err_cnt - e0, 0)

    // Missing ACK on 0x3C: error pulse, no done, bus released.
    // Frame: stop=1 parity=1 data=3C start=0 -> 110_0111_1000
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'h3C, 1'b0, 1'b0, frame, inh_len, oe_pre, oe_post);
    `CHK("nack_frame", frame, 11'h678)
    `CHK("nack_error_once", err_cnt - e0, 1)
    `CHK("nack_no_done", done_cnt - d0, 0)
    `CHK("nack_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00)
    `CHK("nack_ready", tx_ready, 1'b1)

    // Reset in DATA: after two falls of 0xA5, bit1=0 so data is pulled low.
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 10000) begin
      n++;
      @(posedge clk); #1;
    end
    repeat (20) @(posedge clk);
    #1;
    for (int k = 1; k <= 2; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      dev_clk_low = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
    end
    `CHK("data_bit1_driven", ps2_data_oe, 1'b1)
    #2;
    reset_n = 1'b0;
    #1;
    `CHK("midreset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00)
    `CHK("midreset_busy", busy, 1'b0)
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    `CHK("postreset_ready", tx_ready, 1'b1)
    `CHK("postreset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0)

    // Device never clocks after the request: block keeps waiting.
    e0 = err_cnt;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 10000) begin
      n++;
      @(posedge clk); #1;
    end
    repeat (3000) @(posedge clk);
    #1;
    `CHK("stall_busy", busy, 1'b1)
    `CHK("stall_start_held", ps2_data_oe, 1'b1)
    `CHK("stall_no_error", err_cnt - e0, 0)
    reset_n = 1'b0;
    #1;
    `CHK("stall_reset_release", {ps2_clk_oe, ps2_data_oe}, 2'b00)
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
